// File: rtl/abs_diff_sweep_checker.sv
// abs_diff_sweep_checker: sweeps all input vectors through an approximate |a-b| circuit
// and accumulates worst-case, total and over-threshold error against the exact result.
module abs_diff_sweep_checker #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2,
  parameter int ET    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W-1:0]       worst_vec,
  output logic [IN_W+OUT_W-1:0] sum_err,
  output logic [IN_W:0]         fail_cnt,
  output logic                  pass
);
  localparam int H = IN_W / 2;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic             s1_v;
  logic [IN_W-1:0]  s1_vec;
  logic [OUT_W-1:0] s1_out;
  logic [H-1:0]     a, b;
  logic [OUT_W-1:0] exact, err;
  logic             over;

  always_comb begin
    a     = s1_vec[H-1:0];
    b     = s1_vec[IN_W-1:H];
    exact = OUT_W'(a > b ? a - b : b - a);
    err   = s1_out > exact ? s1_out - exact : exact - s1_out;
    over  = 32'(err) > ET;
  end

  assign pass = done && (32'(max_err) <= ET);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s1_v      <= 1'b0;
      s1_vec    <= '0;
      s1_out    <= '0;
      max_err   <= '0;
      worst_vec <= '0;
      sum_err   <= '0;
      fail_cnt  <= '0;
    end else begin
      s1_v   <= state == SWEEP;
      s1_vec <= dut_in;
      s1_out <= dut_out;
      if (s1_v) begin
        sum_err  <= sum_err + (IN_W+OUT_W)'(err);
        fail_cnt <= fail_cnt + {{IN_W{1'b0}}, over};
        if (err > max_err) begin
          max_err   <= err;
          worst_vec <= s1_vec;
        end
      end
      if ((state == IDLE || state == DONE) && start) begin
        state     <= SWEEP;
        busy      <= 1'b1;
        done      <= 1'b0;
        dut_in    <= '0;
        max_err   <= '0;
        worst_vec <= '0;
        sum_err   <= '0;
        fail_cnt  <= '0;
      end else if (state == SWEEP) begin
        if (dut_in == '1) state <= DRAIN;
        else dut_in <= dut_in + IN_W'(1);
      end else if (state == DRAIN && s1_v) begin
        // s1_v here carries the final vector, which accumulates on this same edge
        state  <= DONE;
        done   <= 1'b1;
        busy   <= 1'b0;
        dut_in <= '0;
      end
    end
  end
endmodule

// File: tb/tb_abs_diff_sweep_checker.sv
// tb_abs_diff_sweep_checker: scoreboard bench driving several approximate abs_diff models.
module tb_abs_diff_sweep_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dut_in;
  logic [1:0] dut_out;
  logic       busy, done, pass;
  logic [1:0] max_err;
  logic [3:0] worst_vec;
  logic [5:0] sum_err;
  logic [4:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;

  typedef struct {int m; int w; int s; int f; int p; int c;} exp_t;
  exp_t sb[$];

  abs_diff_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .max_err(max_err), .worst_vec(worst_vec),
    .sum_err(sum_err), .fail_cnt(fail_cnt), .pass(pass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0 exact, 1 stuck-at-0, 2 stuck-at-3, 3 exact with LSB flipped, 4 exact except vectors 6 and 12
  logic [1:0] ex;
  always_comb begin
    ex = dut_in[1:0] > dut_in[3:2] ? dut_in[1:0] - dut_in[3:2] : dut_in[3:2] - dut_in[1:0];
    dut_out = mode == 1 ? 2'd0 :
              mode == 2 ? 2'd3 :
              mode == 3 ? ex ^ 2'd1 :
              mode == 4 ? (dut_in == 4'd6 ? 2'd3 : dut_in == 4'd12 ? 2'd1 : ex) : ex;
  end

  task automatic check(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  logic done_q = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        check("max_err", max_err, e.m);
        check("worst_vec", worst_vec, e.w);
        check("sum_err", sum_err, e.s);
        check("fail_cnt", fail_cnt, e.f);
        check("pass", pass, e.p);
        check("done_cycle", cyc, e.c);
      end
    end
    done_q = done;
  end

  task automatic chk_reset();
    check("rst_dut_in", dut_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_max_err", max_err, 0);
    check("rst_worst_vec", worst_vec, 0);
    check("rst_sum_err", sum_err, 0);
    check("rst_fail_cnt", fail_cnt, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done within 40 cycles");
    end
    @(negedge clk);
  endtask

  task automatic run(int m, int em, int ew, int es, int ef, int ep);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    sb.push_back('{em, ew, es, ef, ep, cyc + 18});
    @(negedge clk);
    start = 1'b0;
    check("start_done_clear", done, 0);
    check("start_busy", busy, 1);
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    // exact model with per-cycle dut_in trace and an ignored start at E5
    @(negedge clk);
    start = 1'b1;
    sb.push_back('{0, 0, 0, 0, 1, cyc + 18});
    @(negedge clk);
    start = 1'b0;
    check("trace_in_0", dut_in, 0);
    check("trace_busy_0", busy, 1);
    for (int k = 1; k <= 17; k++) begin
      start = (k == 5);
      @(negedge clk);
      check($sformatf("trace_in_%0d", k), dut_in, k <= 15 ? k : (k == 16 ? 15 : 0));
      check($sformatf("trace_busy_%0d", k), busy, k < 17 ? 1 : 0);
      check($sformatf("trace_done_%0d", k), done, k == 17 ? 1 : 0);
    end
    start = 1'b0;
    @(negedge clk);
    run(1, 3, 3, 20, 6, 0);
    run(2, 3, 0, 28, 10, 0);
    run(3, 1, 0, 16, 0, 1);
    run(4, 2, 6, 4, 2, 0);
    run(4, 2, 6, 4, 2, 0);
    // reset sampled at E8 aborts the sweep, then a start held during reset is ignored
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    start = 1'b1;
    @(negedge clk);
    chk_reset();
    start = 1'b0;
    rst_n = 1'b1;
    run(1, 3, 3, 20, 6, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
